hilo_ctrl: RTL
==============

Name: hilo_ctrl

Overview:
Owns the architectural HI/LO register pair and sequences every operation that writes it: MTHI, MTLO, MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV and DIVU.
It accepts one request per idle cycle from the execute stage, runs multi-cycle multiply and divide, and commits the result atomically to HI/LO.
It drives busy so the pipeline stalls MFHI/MFLO and further HI/LO ops, and it aborts cleanly on flush from an exception or branch kill.

Parameters:
MUL_LAT, 2, edges from accept to HI/LO commit for multiply-class ops (legal range 1..4).
DIV_ITERS, 32, restoring-division iterations (fixed at 32; parameter exists for bench shortening only).

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
req_valid  in  1  request present this cycle
req_op  in  op_t  decoded operation
req_vs  in  32  rs operand value
req_vt  in  32  rt operand value
req_wr  in  write_hilo_t  decoded HI/LO write intent (valid_hi, valid_lo, hi, lo)
flush  in  1  kill in-flight op
ready  out  1  state==IDLE; request accepted at edge iff req_valid && ready && !flush
busy  out  1  state!=IDLE
done  out  1  one-cycle pulse on the cycle after a multi-cycle commit
hi  out  32  committed HI
lo  out  32  committed LO

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, done=0, counters=0, internal operand/product registers=0. Reset mid-operation drops the op entirely.
- Only ops with req_wr.valid_hi or valid_lo set are acted on. Other ops are ignored even if req_valid is high.
- MTHI/MTLO: committed at the accept edge. Only the selected half is written, with req_vs. State stays IDLE; no done pulse.
- MULT/MULTU: 64-bit signed/unsigned product computed and registered at accept. State goes to MUL_WAIT with cnt=MUL_LAT-1. Commit {hi,lo}=product at the edge where cnt==0 in MUL_WAIT.
- MADD/MADDU: commit {hi,lo}+product. MSUB/MSUBU: commit {hi,lo}-product. Arithmetic is mod 2^64. The accumulate uses HI/LO values current at commit time; these cannot change in between because MTHI/MTLO are blocked while busy.
- MUL_LAT=1: state MUL_WAIT lasts one cycle.
- DIV/DIVU: at accept, latch operand magnitudes (absolute values for DIV) and sign flags. Enter DIV_ITER.
- DIV_ITER: one quotient bit per edge, DIV_ITERS edges. Then DIV_FIX for one edge: apply signs (quotient negative iff signs differ; remainder takes dividend sign) and commit lo=quotient, hi=remainder.
- Total divide latency is DIV_ITERS+1 edges after the accept edge (33 by default).
- Divide by zero: hi=req_vs, lo=32'hFFFF_FFFF for both DIV and DIVU, with no sign fix. Full latency is still spent.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- States and transitions:
  - IDLE -> MUL_WAIT on a multiply-class accept.
  - IDLE -> DIV_ITER on a divide accept.
  - MUL_WAIT -> IDLE on commit.
  - DIV_ITER -> DIV_FIX after the last iteration.
  - DIV_FIX -> IDLE.
- done=1 for the single cycle following any MUL_WAIT or DIV_FIX commit.
- flush in any non-IDLE state: go to IDLE next edge, no HI/LO update, no done. This includes flush on the commit edge; flush wins.
- flush in IDLE suppresses acceptance, including MTHI/MTLO.
- req_valid while busy: ignored. Upstream holds the request.
- hi/lo are register outputs with no bypass. A consumer reads the new value the cycle after commit.

Decomposition:
- hilo_state_t enum (IDLE, MUL_WAIT, DIV_ITER, DIV_FIX) and the DIV_LAT constant go in mycpu.svh next to write_hilo_t. op_t is reused unchanged.
- One sub-module, div_iter32: the restoring divider datapath (remainder/quotient shift registers, start and step inputs, unsigned only). Sign handling, divide-by-zero and overflow handling stay in hilo_ctrl.

Test Plan:
- Reset then MTHI vs=0x1234_5678, next cycle MTLO vs=0xDEAD_BEEF -> hi=0x1234_5678, lo=0xDEAD_BEEF; busy never asserts.
- MULT vs=0xFFFF_FFFE, vt=3 -> busy for 2 cycles, then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA, done pulse. MULTU same operands -> hi=0x2, lo=0xFFFF_FFFA.
- With hi=0, lo=1: MSUBU vs=1, vt=2 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFFF.
- DIV vs=0xFFFF_FFF9 (-7), vt=2 -> hi/lo unchanged for 32 edges, then lo=0xFFFF_FFFD, hi=0xFFFF_FFFF on edge 33. DIV vs=0x8000_0000, vt=0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- DIVU vs=100, vt=0 -> after 33 edges hi=100, lo=0xFFFF_FFFF.
- DIVU in flight, flush at edge 10 -> IDLE next edge, hi/lo keep pre-op values, no done. Async reset asserted mid-MULT -> hi=lo=0 immediately, ready=1 after release.

Source files
------------

// File: rtl/hilo_ctrl_pkg.sv
// Shared types for the HI/LO controller: decoded op, HI/LO write intent,
// controller state and the divide latency constant.
package hilo_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MTHI  = 4'd1,
        OP_MTLO  = 4'd2,
        OP_MULT  = 4'd3,
        OP_MULTU = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_DIV   = 4'd9,
        OP_DIVU  = 4'd10
    } op_t;

    typedef struct packed {
        logic        valid_hi;
        logic        valid_lo;
        logic [31:0] hi;
        logic [31:0] lo;
    } write_hilo_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_ITER = 2'd2,
        DIV_FIX  = 2'd3
    } hilo_state_t;

    typedef enum logic [1:0] {
        ACC_SET = 2'd0,
        ACC_ADD = 2'd1,
        ACC_SUB = 2'd2
    } acc_mode_t;

    // Edges from divide accept to HI/LO commit with the default 32 iterations.
    localparam int DIV_LAT = 33;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_ctrl_div_iter32.sv
// Unsigned restoring divider: start loads the operands, each step retires
// one quotient bit, MSB first.
module div_iter32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_step,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [32:0] w_shift;
    logic [33:0] w_diff;
    logic        w_fits;
    logic        w_unused_bit;

    // Partial remainder stays below the divisor, so a fitting trial always fits in 32 bits.
    assign w_shift      = {r_rem, r_quo[31]};
    assign w_diff       = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_fits       = ~w_diff[33];
    assign w_unused_bit = w_diff[32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
        end else if (i_step) begin
            r_rem <= w_fits ? w_diff[31:0] : w_shift[31:0];
            r_quo <= {r_quo[30:0], w_fits};
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register owner: immediate MTHI/MTLO, fixed-latency multiply/accumulate
// and iterative divide, all committed atomically and killable by flush.
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int MUL_LAT   = 2,
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  op_t         req_op,
    input  logic [31:0] req_vs,
    input  logic [31:0] req_vt,
    input  write_hilo_t req_wr,
    input  logic        flush,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output hilo_state_t dbg_state
);

    // Handshake: a request transfers on the edge where req_valid && ready && !flush
    // and it carries a HI/LO write; otherwise upstream keeps holding it.

    localparam logic [5:0] MUL_CNT0 = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_CNT0 = 6'(DIV_ITERS - 1);

    hilo_state_t r_state, w_state_nx;
    logic [5:0]  r_cnt, w_cnt_nx;
    logic [31:0] r_hi, r_lo, w_hi_nx, w_lo_nx;
    logic        r_done, w_done_nx;
    logic [63:0] r_prod;
    acc_mode_t   r_acc;
    logic        r_q_neg, r_r_neg, r_div0;
    logic [31:0] r_vs;

    logic        w_accept, w_is_mul, w_is_div, w_signed_mul, w_signed_div;
    logic        w_mul_load, w_div_start, w_div_step;
    logic [63:0] w_prod, w_hilo, w_mul_res;
    acc_mode_t   w_acc_mode;
    logic [31:0] w_dvd_mag, w_dvs_mag, w_quo, w_rem, w_q_fix, w_r_fix;
    logic        w_unused;

    assign w_unused = ^{req_wr.hi, req_wr.lo};

    assign w_accept     = req_valid && (r_state == IDLE) && !flush
                          && (req_wr.valid_hi || req_wr.valid_lo);
    assign w_is_mul     = req_op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    assign w_is_div     = req_op inside {OP_DIV, OP_DIVU};
    assign w_signed_mul = req_op inside {OP_MULT, OP_MADD, OP_MSUB};
    assign w_signed_div = (req_op == OP_DIV);

    assign w_prod = w_signed_mul
                  ? ({{32{req_vs[31]}}, req_vs} * {{32{req_vt[31]}}, req_vt})
                  : ({32'd0, req_vs} * {32'd0, req_vt});

    always_comb begin
        w_acc_mode = ACC_SET;
        case (req_op)
            OP_MADD, OP_MADDU: w_acc_mode = ACC_ADD;
            OP_MSUB, OP_MSUBU: w_acc_mode = ACC_SUB;
            default:           w_acc_mode = ACC_SET;
        endcase
    end

    assign w_dvd_mag = w_signed_div ? abs32(req_vs) : req_vs;
    assign w_dvs_mag = w_signed_div ? abs32(req_vt) : req_vt;

    div_iter32 u_div (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_div_start),
        .i_step      (w_div_step),
        .i_dividend  (w_dvd_mag),
        .i_divisor   (w_dvs_mag),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Accumulate reads HI/LO at commit; they are frozen while busy.
    assign w_hilo = {r_hi, r_lo};
    always_comb begin
        w_mul_res = r_prod;
        case (r_acc)
            ACC_ADD: w_mul_res = w_hilo + r_prod;
            ACC_SUB: w_mul_res = w_hilo - r_prod;
            default: w_mul_res = r_prod;
        endcase
    end

    assign w_q_fix = r_q_neg ? (~w_quo + 32'd1) : w_quo;
    assign w_r_fix = r_r_neg ? (~w_rem + 32'd1) : w_rem;

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_hi_nx     = r_hi;
        w_lo_nx     = r_lo;
        w_done_nx   = 1'b0;
        w_mul_load  = 1'b0;
        w_div_start = 1'b0;
        w_div_step  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (req_op == OP_MTHI) begin
                        w_hi_nx = req_vs;
                    end else if (req_op == OP_MTLO) begin
                        w_lo_nx = req_vs;
                    end else if (w_is_mul) begin
                        w_mul_load = 1'b1;
                        w_cnt_nx   = MUL_CNT0;
                        w_state_nx = MUL_WAIT;
                    end else if (w_is_div) begin
                        w_div_start = 1'b1;
                        w_cnt_nx    = DIV_CNT0;
                        w_state_nx  = DIV_ITER;
                    end
                end
            end
            MUL_WAIT: begin
                if (flush) begin
                    w_state_nx = IDLE;
                end else if (r_cnt == 6'd0) begin
                    {w_hi_nx, w_lo_nx} = w_mul_res;
                    w_done_nx  = 1'b1;
                    w_state_nx = IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 6'd1;
                end
            end
            DIV_ITER: begin
                if (flush) begin
                    w_state_nx = IDLE;
                end else begin
                    w_div_step = 1'b1;
                    if (r_cnt == 6'd0) begin
                        w_state_nx = DIV_FIX;
                    end else begin
                        w_cnt_nx = r_cnt - 6'd1;
                    end
                end
            end
            DIV_FIX: begin
                if (flush) begin
                    w_state_nx = IDLE;
                end else begin
                    // Divide by zero bypasses sign fix-up entirely.
                    if (r_div0) begin
                        w_hi_nx = r_vs;
                        w_lo_nx = 32'hFFFF_FFFF;
                    end else begin
                        w_hi_nx = w_r_fix;
                        w_lo_nx = w_q_fix;
                    end
                    w_done_nx  = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_prod  <= '0;
            r_acc   <= ACC_SET;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_div0  <= 1'b0;
            r_vs    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
            r_done  <= w_done_nx;
            if (w_mul_load) begin
                r_prod <= w_prod;
                r_acc  <= w_acc_mode;
            end
            if (w_div_start) begin
                r_q_neg <= w_signed_div && (req_vs[31] ^ req_vt[31]);
                r_r_neg <= w_signed_div && req_vs[31];
                r_div0  <= (req_vt == 32'd0);
                r_vs    <= req_vs;
            end
        end
    end

    assign ready     = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;

endmodule
